// File: rtl/prefetch_ctrl_if.sv
// Memory-request and stream-buffer handshake bundle for the instruction prefetcher.
// The controller drives the request/write side through the master modport.
interface prefetch_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              oMemReq;
  logic [ADDR_W-3:0] oMemAddr;
  logic              iMemGnt;
  logic              iMemAck;
  logic              oAckWr;
  logic [1:0]        oMemIndex;
  logic              iConsume;

  modport master (
    output oMemReq,
    output oMemAddr,
    output oAckWr,
    output oMemIndex,
    input  iMemGnt,
    input  iMemAck,
    input  iConsume
  );

  modport slave (
    input  oMemReq,
    input  oMemAddr,
    input  oAckWr,
    input  oMemIndex,
    output iMemGnt,
    output iMemAck,
    output iConsume
  );
endinterface

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch sequencer: issues word fetches bounded by outstanding and
// buffer-credit limits, tags returned words with their entry byte offset, and
// discards stale returns after a jump.
module prefetch_ctrl #(
  parameter int unsigned          ADDR_W     = 20,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = 20'hFFFF0,
  parameter int unsigned          MAX_OUT    = 2,
  parameter int unsigned          CREDITS    = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iJump,
  input  logic [ADDR_W-1:0] iJumpAddr,
  prefetch_ctrl_if.master   mem,
  output logic [1:0]        oOutstanding
);

  localparam logic [1:0]        MaxOut  = MAX_OUT[1:0];
  localparam logic [3:0]        Credits = CREDITS[3:0];
  localparam logic [ADDR_W-3:0] AddrOne = {{(ADDR_W-3){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-3:0] addrQ, addrD;
  logic [1:0]        firstOffQ, firstOffD;
  logic              firstPendQ, firstPendD;
  logic [1:0]        outQ, outD;
  logic [2:0]        bufQ, bufD;
  logic [1:0]        discQ, discD;

  logic       ackValid;
  logic       memReq;
  logic       grant;
  logic       ackWr;
  logic       drop;
  logic [3:0] inUse;

  // Request/ack qualification and the combinational outputs.
  always_comb begin
    // An ack with nothing outstanding is a protocol error and is ignored entirely.
    ackValid = mem.iMemAck & (outQ != 2'd0);
    // Stale requests already lost their buffer slot, so they do not consume credit.
    inUse    = {2'b00, outQ} - {2'b00, discQ} + {1'b0, bufQ};
    memReq   = (stateQ != StIdle) & (outQ < MaxOut) & (inUse < Credits) & ~iJump;
    grant    = mem.iMemGnt & memReq;
    ackWr    = ackValid & (discQ == 2'd0) & ~iJump;
    drop     = ackValid & (discQ != 2'd0) & ~iJump;

    mem.oMemReq   = memReq;
    mem.oMemAddr  = addrQ;
    mem.oAckWr    = ackWr;
    mem.oMemIndex = (ackWr & firstPendQ) ? firstOffQ : 2'b00;
    oOutstanding  = outQ;
  end

  // Datapath next state: address, entry offset, and the three counters.
  always_comb begin
    addrD      = addrQ;
    firstOffD  = firstOffQ;
    firstPendD = firstPendQ;
    outD       = outQ;
    bufD       = bufQ;
    discD      = discQ;

    if (iJump) begin
      addrD      = iJumpAddr[ADDR_W-1:2];
      firstOffD  = iJumpAddr[1:0];
      firstPendD = 1'b1;
      bufD       = 3'd0;
      // No grant is possible this cycle, so every remaining request is stale.
      outD       = outQ - {1'b0, ackValid};
      discD      = outQ - {1'b0, ackValid};
    end else begin
      if (grant) begin
        addrD = addrQ + AddrOne;
      end

      unique case ({grant, ackValid})
        2'b10:   outD = outQ + 2'd1;
        2'b01:   outD = outQ - 2'd1;
        default: outD = outQ;
      endcase

      if (drop) begin
        discD = discQ - 2'd1;
      end

      if (ackWr) begin
        firstPendD = 1'b0;
      end

      if (ackWr && !mem.iConsume && ({1'b0, bufQ} < Credits)) begin
        bufD = bufQ + 3'd1;
      end else if (!ackWr && mem.iConsume && (bufQ != 3'd0)) begin
        bufD = bufQ - 3'd1;
      end
    end
  end

  // FSM next state: IDLE until started, FLUSH while stale returns remain.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (iJump || iStart) begin
          stateD = StRun;
        end
      end
      StRun, StFlush: begin
        if (iJump) begin
          stateD = (discD != 2'd0) ? StFlush : StRun;
        end else if (stateQ == StFlush && discD == 2'd0) begin
          stateD = StRun;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ     <= StIdle;
      addrQ      <= RESET_ADDR[ADDR_W-1:2];
      firstOffQ  <= RESET_ADDR[1:0];
      firstPendQ <= 1'b1;
      outQ       <= 2'd0;
      bufQ       <= 3'd0;
      discQ      <= 2'd0;
    end else begin
      stateQ     <= stateD;
      addrQ      <= addrD;
      firstOffQ  <= firstOffD;
      firstPendQ <= firstPendD;
      outQ       <= outD;
      bufQ       <= bufD;
      discQ      <= discD;
    end
  end

  // Counter invariants.
  aOutBound : assert property (@(posedge iClk) disable iff (iRst) outQ <= MaxOut);
  aDiscBound : assert property (@(posedge iClk) disable iff (iRst) discQ <= outQ);
  aCredBound : assert property (@(posedge iClk) disable iff (iRst) inUse <= Credits);

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Bench for prefetch_ctrl: directed vector table, reset corner case, then random
// traffic against a queue-based reference model.
module tb_prefetch_ctrl;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic        iJump;
  logic [19:0] iJumpAddr;
  logic [1:0]  oOutstanding;

  int tests = 0;
  int fails = 0;

  prefetch_ctrl_if #(.ADDR_W(20)) bus ();

  prefetch_ctrl #(
    .ADDR_W    (20),
    .RESET_ADDR(20'hFFFF0),
    .MAX_OUT   (2),
    .CREDITS   (4)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iJump       (iJump),
    .iJumpAddr   (iJumpAddr),
    .mem         (bus),
    .oOutstanding(oOutstanding)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic        st;
    logic        jp;
    logic [19:0] ja;
    logic        g;
    logic        a;
    logic        c;
    logic        req;
    logic [17:0] addr;
    logic        wr;
    logic [1:0]  idx;
    logic [1:0]  outs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic jp, logic [19:0] ja, logic g, logic a, logic c,
                              logic req, logic [17:0] addr, logic wr, logic [1:0] idx,
                              logic [1:0] outs);
    vec_t v;
    v.st = st; v.jp = jp; v.ja = ja; v.g = g; v.a = a; v.c = c;
    v.req = req; v.addr = addr; v.wr = wr; v.idx = idx; v.outs = outs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic jp, input logic [19:0] ja,
                       input logic g, input logic a, input logic c);
    iStart       = st;
    iJump        = jp;
    iJumpAddr    = ja;
    bus.iMemGnt  = g;
    bus.iMemAck  = a;
    bus.iConsume = c;
  endtask

  // Reference model: one queue entry per granted request, flagged stale on jump.
  bit          mRun;
  logic [17:0] mAddr;
  logic [1:0]  mOff;
  bit          mPend;
  bit          staleQ[$];
  int          mBuf;

  task automatic modelReset();
    mRun  = 0;
    mAddr = 18'h3FFFC;
    mOff  = 2'd0;
    mPend = 1;
    staleQ.delete();
    mBuf  = 0;
  endtask

  function automatic int liveCount();
    int n = 0;
    foreach (staleQ[i]) if (!staleQ[i]) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] rnd;
    logic        st, jp, g, a, c;
    logic [19:0] ja;
    bit          eReq, eWr, ackV;
    logic [1:0]  eIdx;
    int          qs;

    iRst = 1'b1;
    drive(0, 0, 20'h0, 0, 0, 0);
    @(negedge iClk);
    check("resetReq", {31'b0, bus.oMemReq}, 32'd0);
    check("resetOut", {30'b0, oOutstanding}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // st jp ja g a c | req addr wr idx out
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 0, 0, 18'h3FFFC, 0, 0, 0));
    vecs.push_back(mk(1, 0, 20'h0,     1, 0, 0, 0, 18'h3FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h3FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h3FFFD, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 0, 18'h3FFFE, 0, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 1, 0, 0, 18'h3FFFE, 1, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h3FFFE, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 1, 0, 0, 18'h3FFFF, 1, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h3FFFF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 1, 0, 0, 18'h00000, 1, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 0, 18'h00000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 1, 0, 0, 18'h00000, 1, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 0, 18'h00000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 1, 0, 18'h00000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h00000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 0, 18'h00001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 1, 0, 18'h00001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 1, 1, 18'h00001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h00001, 0, 0, 1));
    vecs.push_back(mk(0, 1, 20'h01235, 0, 1, 0, 0, 18'h00002, 0, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h0048D, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     0, 1, 0, 0, 18'h0048E, 0, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     0, 1, 0, 1, 18'h0048E, 1, 1, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h0048E, 0, 0, 0));
    vecs.push_back(mk(0, 1, 20'h01235, 1, 0, 0, 0, 18'h0048F, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 0, 1, 18'h0048D, 0, 0, 1));
    vecs.push_back(mk(0, 1, 20'hFFFFC, 0, 0, 0, 0, 18'h0048D, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h3FFFF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     1, 1, 0, 0, 18'h00000, 0, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     1, 0, 0, 1, 18'h00000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 0, 0, 18'h00001, 0, 0, 2));
    vecs.push_back(mk(0, 1, 20'h00100, 0, 0, 0, 0, 18'h00001, 0, 0, 2));
    vecs.push_back(mk(0, 0, 20'h0,     0, 0, 0, 0, 18'h00040, 0, 0, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].jp, vecs[i].ja, vecs[i].g, vecs[i].a, vecs[i].c);
      #2;
      check($sformatf("vec%0d.req", i), {31'b0, bus.oMemReq}, {31'b0, vecs[i].req});
      check($sformatf("vec%0d.addr", i), {14'b0, bus.oMemAddr}, {14'b0, vecs[i].addr});
      check($sformatf("vec%0d.wr", i), {31'b0, bus.oAckWr}, {31'b0, vecs[i].wr});
      check($sformatf("vec%0d.out", i), {30'b0, oOutstanding}, {30'b0, vecs[i].outs});
      if (vecs[i].wr) begin
        check($sformatf("vec%0d.idx", i), {30'b0, bus.oMemIndex}, {30'b0, vecs[i].idx});
      end
      @(negedge iClk);
    end

    // Asynchronous reset while flushing with two outstanding.
    drive(0, 0, 20'h0, 1, 1, 0);
    #2;
    iRst = 1'b1;
    #1;
    check("asyncRst.req", {31'b0, bus.oMemReq}, 32'd0);
    check("asyncRst.wr", {31'b0, bus.oAckWr}, 32'd0);
    check("asyncRst.idx", {30'b0, bus.oMemIndex}, 32'd0);
    check("asyncRst.out", {30'b0, oOutstanding}, 32'd0);
    check("asyncRst.addr", {14'b0, bus.oMemAddr}, 32'h3FFFC);
    @(negedge iClk);
    iRst = 1'b0;
    #2;
    check("postRst.wr", {31'b0, bus.oAckWr}, 32'd0);
    check("postRst.req", {31'b0, bus.oMemReq}, 32'd0);
    @(negedge iClk);
    check("postRst.out", {30'b0, oOutstanding}, 32'd0);
    check("postRst.addr", {14'b0, bus.oMemAddr}, 32'h3FFFC);
    drive(0, 0, 20'h0, 0, 0, 0);
    modelReset();

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom_range(0, 15) == 0);
      jp  = ($urandom_range(0, 24) == 0);
      rnd = $urandom();
      ja  = rnd[19:0];
      g   = $urandom_range(0, 1) == 1;
      a   = $urandom_range(0, 2) != 0;
      c   = $urandom_range(0, 2) == 0;

      qs   = staleQ.size();
      eReq = mRun && (qs < 2) && ((liveCount() + mBuf) < 4) && !jp;
      ackV = a && (qs > 0);
      eWr  = ackV && !staleQ[0] && !jp;
      eIdx = (eWr && mPend) ? mOff : 2'd0;

      drive(st, jp, ja, g, a, c);
      #2;
      check("rnd.req", {31'b0, bus.oMemReq}, {31'b0, eReq});
      check("rnd.addr", {14'b0, bus.oMemAddr}, {14'b0, mAddr});
      check("rnd.wr", {31'b0, bus.oAckWr}, {31'b0, eWr});
      check("rnd.idx", {30'b0, bus.oMemIndex}, {30'b0, eIdx});
      check("rnd.out", {30'b0, oOutstanding}, qs);

      if (jp) begin
        if (ackV) void'(staleQ.pop_front());
        foreach (staleQ[i]) staleQ[i] = 1;
        mAddr = ja[19:2];
        mOff  = ja[1:0];
        mPend = 1;
        mBuf  = 0;
        mRun  = 1;
      end else begin
        if (st) mRun = 1;
        if (ackV) void'(staleQ.pop_front());
        if (g && eReq) begin
          staleQ.push_back(0);
          mAddr = mAddr + 18'd1;
        end
        if (eWr) mPend = 0;
        if (eWr && !c) mBuf++;
        else if (!eWr && c && mBuf > 0) mBuf--;
      end
      @(negedge iClk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
